// File: rtl/pipe_adder_pkg.sv
// Shared constants and result bundle for the pipelined adder.
// Optional subtract mode is enabled by defining PIPE_ADDER_SUB_EN.
package pipe_adder_pkg;

    localparam int DEF_WIDTH  = 16;
    localparam int DEF_STAGES = 4;

    typedef struct packed {
        logic [DEF_WIDTH-1:0] sum;
        logic                 co;
        logic                 ovf;
    } res_t;

endpackage

// File: rtl/adder_slice.sv
// Combinational ripple adder for one slice of the pipelined adder.
// Exposes the carry into the slice MSB for signed overflow detection.
module adder_slice #(
    parameter int W = 4
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         ci,
    output logic [W-1:0] s,
    output logic         co,
    output logic         cm
);

    logic [W:0] c;

    always_comb begin
        c    = '0;
        s    = '0;
        c[0] = ci;
        for (int i = 0; i < W; i++) begin
            s[i]   = a[i] ^ b[i] ^ c[i];
            c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
    end

    assign co = c[W];
    assign cm = c[W-1];

endmodule

// File: rtl/pipe_adder.sv
// Pipelined carry-sliced adder with valid/ready flow control.
// Define PIPE_ADDER_SUB_EN to add the sub port (a + ~b + 1).
module pipe_adder
    import pipe_adder_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int STAGES = DEF_STAGES
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
`ifdef PIPE_ADDER_SUB_EN
    input  logic             sub,
`endif
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             co,
    output logic             ovf
);

    localparam int SW = WIDTH / STAGES;

    logic             adv;
    logic [WIDTH-1:0] b_in;
    logic             c_in;

    logic             v_q [STAGES];
    logic             c_q [STAGES];
    logic             o_q [STAGES];
    logic [WIDTH-1:0] a_q [STAGES];
    logic [WIDTH-1:0] b_q [STAGES];
    logic [WIDTH-1:0] s_q [STAGES];

    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

`ifdef PIPE_ADDER_SUB_EN
    assign b_in = sub ? ~b : b;
    assign c_in = sub ? 1'b1 : ci;
`else
    assign b_in = b;
    assign c_in = ci;
`endif

    // Each stage carries the not-yet-added operand slices forward
    // alongside the partial sum so every slice meets its carry.
    for (genvar k = 0; k < STAGES; k++) begin : g_st
        logic             vi;
        logic             ck;
        logic [WIDTH-1:0] ai;
        logic [WIDTH-1:0] bi;
        logic [WIDTH-1:0] si;
        logic [WIDTH-1:0] sn;
        logic [SW-1:0]    ss;
        logic             sc;
        logic             sm;

        if (k == 0) begin : g_src
            assign vi = in_valid;
            assign ck = c_in;
            assign ai = a;
            assign bi = b_in;
            assign si = '0;
        end else begin : g_prv
            assign vi = v_q[k-1];
            assign ck = c_q[k-1];
            assign ai = a_q[k-1];
            assign bi = b_q[k-1];
            assign si = s_q[k-1];
        end

        adder_slice #(
            .W (SW)
        ) u_slice (
            .a  (ai[k*SW +: SW]),
            .b  (bi[k*SW +: SW]),
            .ci (ck),
            .s  (ss),
            .co (sc),
            .cm (sm)
        );

        always_comb begin
            sn                = si;
            sn[k*SW +: SW]    = ss;
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                v_q[k] <= 1'b0;
                c_q[k] <= 1'b0;
                o_q[k] <= 1'b0;
                a_q[k] <= '0;
                b_q[k] <= '0;
                s_q[k] <= '0;
            end else if (adv) begin
                v_q[k] <= vi;
                c_q[k] <= sc;
                o_q[k] <= sm ^ sc;
                a_q[k] <= ai;
                b_q[k] <= bi;
                s_q[k] <= sn;
            end
        end
    end

    assign out_valid = v_q[STAGES-1];
    assign sum       = s_q[STAGES-1];
    assign co        = c_q[STAGES-1];
    assign ovf       = o_q[STAGES-1];

endmodule
